instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 16: number of 32-bit words in the attached instruction memory, which is word-indexed.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: begin or restart fetching at word 0; sampled only in IDLE or HALT.
REQ-005 The block SHALL have port imem_addr, output, 32: word index driven to the combinational instruction memory.
REQ-006 The block SHALL have port imem_instr, input, 32: instruction word returned combinationally for imem_addr.
REQ-007 The block SHALL have port instr, output, 32: registered instruction presented downstream.
REQ-008 The block SHALL have port pc, output, 32: word index of the instruction on instr.
REQ-009 The block SHALL have port valid, output, 1: instr/pc hold a fetched word.
REQ-010 The block SHALL have port ready, input, 1: downstream accepts the word on a cycle where valid=1.
REQ-011 The block SHALL have port redirect, input, 1: branch/jump request; flushes and reloads the fetch index.
REQ-012 The block SHALL have port redirect_addr, input, 32: word index target, sampled when redirect=1.
REQ-013 The block SHALL have port done, output, 1: the program ran off the end of memory and the last word was consumed.
REQ-014 The block SHALL have port fault, output, 1: a redirect targeted an index >= IMEM_DEPTH; sticky until reset or start.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH and HALT, with an internal fetch index fpc (32 bits); imem_addr SHALL equal fpc at all times.
REQ-016 In IDLE, when start=1, the block SHALL set fpc<=0 and go to FETCH; valid SHALL stay 0.
REQ-017 In FETCH, the block SHALL load a word when valid=0 or ready=1, with redirect=0: instr<=imem_instr, pc<=fpc, valid<=1, fpc<=fpc+1.
REQ-018 In FETCH, when valid=1 and ready=0 (stall), instr, pc, valid and fpc SHALL hold unchanged; imem_addr stays stable.
REQ-019 The latency from start sampled at edge t SHALL be as follows: imem_addr=0 after edge t, and valid=1 with pc=0 after edge t+1.
REQ-020 With ready held at 1, the block SHALL deliver one word per cycle, with pc incrementing by 1.
REQ-021 In FETCH, redirect=1 SHALL take priority over ready and over load: valid<=0 (the held word is discarded even if ready=1) and fpc<=redirect_addr.
REQ-022 Normal fetch SHALL resume on the following cycle, so the first target word appears 2 cycles after the redirect edge.
REQ-023 On a redirect with redirect_addr >= IMEM_DEPTH, the block SHALL set fault<=1, set valid<=0 and go to HALT; fpc is unchanged.
REQ-024 On a load where fpc == IMEM_DEPTH-1, the block SHALL capture the word normally and go to HALT without incrementing fpc.
REQ-025 In HALT, a pending valid word SHALL remain and be handed over under the normal ready rule; no new loads occur and redirect is ignored.
REQ-026 In HALT, done SHALL be 1 when valid=0 and fault=0.
REQ-027 In HALT, when start=1, the block SHALL clear done and fault, set valid<=0 and fpc<=0, and go to FETCH, even while a word is still pending.
REQ-028 In IDLE and HALT, redirect SHALL have no effect.
REQ-029 In FETCH, start SHALL have no effect.
REQ-030 All index arithmetic SHALL be unsigned 32-bit; fpc never wraps because HALT is entered at IMEM_DEPTH-1.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without waiting for clk, force the state to IDLE, fpc=0, valid=0, instr=0, pc=0, done=0 and fault=0.
REQ-032 A reset asserted mid-fetch, mid-stall or in HALT SHALL discard any pending word.
REQ-033 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 The bench SHALL cover the following scenario: memory model word0=0x00011020, word1=0x00011823; start pulse with ready=1 -> after 2 edges valid=1, pc=0, instr=0x00011020; next edge pc=1, instr=0x00011823.
REQ-035 The bench SHALL cover the following scenario: ready=0 for 3 cycles while valid=1 at pc=2 -> instr, pc and imem_addr=3 stable throughout; ready=1 -> pc=3 on the next edge.
REQ-036 The bench SHALL cover the following scenario: redirect=1, redirect_addr=8 with ready=1 at pc=4 -> valid=0 next cycle, then valid=1, pc=8 one cycle later; word 5 is never presented.
REQ-037 The bench SHALL cover the following scenario: free run to pc=15 (IMEM_DEPTH=16) -> HALT; done=1 on the cycle after word 15 is accepted; imem_addr stays 15.
REQ-038 The bench SHALL cover the following scenario: redirect_addr=20 -> fault=1, valid=0, done=0; then start -> fault=0, pc=0 delivered 2 edges later.
REQ-039 The bench SHALL cover the following scenario: rst_n low between clock edges during a stall -> valid=0 and pc=0 immediately; no fetch occurs after release until start.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - instruction fetch controller with stall, redirect, halt and fault handling
//
// Purpose: walks a word-indexed, combinational instruction memory from word 0,
// presenting one registered word at a time downstream under a valid/ready
// handshake. Redirects flush the presented word and reload the fetch index.
// Running off the end of memory or redirecting out of range parks the block in HALT.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   start         in   1   begin/restart at word 0 (honoured in IDLE and HALT)
//   imem_addr     out  32  word index to instruction memory (always the fetch index)
//   imem_instr    in   32  instruction word for imem_addr
//   instr         out  32  registered instruction
//   pc            out  32  word index of instr
//   valid         out  1   instr/pc hold a fetched word
//   ready         in   1   downstream accepts the word while valid=1
//   redirect      in   1   branch/jump request (honoured in FETCH)
//   redirect_addr in   32  redirect target word index
//   done          out  1   last word consumed, no fault
//   fault         out  1   redirect target out of range (sticky)

module instruction_fetch_controller #(
  parameter int IMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  input  logic        ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        done,
  output logic        fault
);

  localparam logic [31:0] LP_DEPTH = 32'(IMEM_DEPTH);
  localparam logic [31:0] LP_LAST  = 32'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_done;
  logic        r_fault;

  // A word may be loaded whenever the output slot is empty or being drained.
  logic w_can_load;
  logic w_redirect_oob;

  assign w_can_load     = ~r_valid | ready;
  assign w_redirect_oob = (redirect_addr >= LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fpc   <= 32'd0;
      r_instr <= 32'd0;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_fpc   <= 32'd0;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_done <= 1'b0;
          if (redirect) begin
            // Redirect wins over any handover: the presented word is dropped.
            r_valid <= 1'b0;
            if (w_redirect_oob) begin
              r_fault <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_fpc <= redirect_addr;
            end
          end else if (w_can_load) begin
            r_instr <= imem_instr;
            r_pc    <= r_fpc;
            r_valid <= 1'b1;
            // The last word is captured without advancing, so fpc never leaves memory.
            if (r_fpc == LP_LAST) begin
              r_state <= S_HALT;
            end else begin
              r_fpc <= r_fpc + 32'd1;
            end
          end
        end

        S_HALT: begin
          if (start) begin
            r_fault <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_fpc   <= 32'd0;
            r_state <= S_FETCH;
          end else begin
            // done is registered from the next value of valid so it rises
            // on the same edge that hands over the final word.
            if (r_valid && ready) begin
              r_valid <= 1'b0;
            end
            r_done <= ~r_fault & ~(r_valid & ~ready);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr = r_fpc;
  assign instr     = r_instr;
  assign pc        = r_pc;
  assign valid     = r_valid;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - self-checking bench for instruction_fetch_controller

module tb_instruction_fetch_controller;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        done;
  logic        fault;

  int checks;
  int errors;

  logic [31:0] mem [DEPTH];

  assign imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[3:0]] : 32'hDEAD_BEEF;

  instruction_fetch_controller #(.IMEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .instr         (instr),
    .pc            (pc),
    .valid         (valid),
    .ready         (ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .done          (done),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a program counter walking an array, a one-word output
  // slot, and a mode number (0 waiting, 1 running, 2 stopped).
  int          m_mode;
  int          m_next;
  bit          m_have;
  int          m_pc;
  logic [31:0] m_word;
  bit          m_fault;

  task automatic model_reset();
    m_mode  = 0;
    m_next  = 0;
    m_have  = 0;
    m_pc    = 0;
    m_word  = 32'd0;
    m_fault = 0;
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      if (start) begin
        m_next = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (redirect) begin
        m_have = 0;
        if (redirect_addr >= 32'(DEPTH)) begin
          m_fault = 1;
          m_mode  = 2;
        end else begin
          m_next = int'(redirect_addr);
        end
      end else if (!m_have || ready) begin
        m_have = 1;
        m_pc   = m_next;
        m_word = mem[m_next];
        if (m_next == DEPTH - 1) m_mode = 2;
        else m_next = m_next + 1;
      end
    end else begin
      if (start) begin
        m_fault = 0;
        m_have  = 0;
        m_next  = 0;
        m_mode  = 1;
      end else if (m_have && ready) begin
        m_have = 0;
      end
    end
  endtask

  // One clock edge: model advances on the same inputs the DUT sees, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
    model_reset();
    #12;
    checks++;
    if (valid !== 1'b0 || pc !== 32'd0 || instr !== 32'd0 || imem_addr !== 32'd0 ||
        done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%0b pc=%0d instr=%h addr=%0d done=%0b fault=%0b, required all zero",
               valid, pc, instr, imem_addr, done, fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL idle_wait: valid=%0b addr=%0d, required 0 and 0", valid, imem_addr);
    end
  endtask

  task automatic test_fetch();
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (imem_addr !== 32'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: addr=%0d valid=%0b, required 0 and 0", imem_addr, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 32'd0 || instr !== 32'h00011020) begin
      errors++;
      $display("FAIL first_word: valid=%0b pc=%0d instr=%h, required 1 0 00011020", valid, pc, instr);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 32'd1 || instr !== 32'h00011823) begin
      errors++;
      $display("FAIL second_word: valid=%0b pc=%0d instr=%h, required 1 1 00011823", valid, pc, instr);
    end
  endtask

  task automatic test_stall();
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || pc !== 32'd2 || instr !== mem[2] || imem_addr !== 32'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b pc=%0d instr=%h addr=%0d, required 1 2 %h 3",
                 i, valid, pc, instr, imem_addr, mem[2]);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 32'd3 || instr !== mem[3]) begin
      errors++;
      $display("FAIL stall_release: valid=%0b pc=%0d instr=%h, required 1 3 %h", valid, pc, instr, mem[3]);
    end
  endtask

  task automatic test_redirect();
    tick();
    redirect = 1'b1; redirect_addr = 32'd8;
    tick();
    redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'd8) begin
      errors++;
      $display("FAIL redirect_flush: valid=%0b addr=%0d, required 0 8", valid, imem_addr);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 32'd8 || instr !== mem[8]) begin
      errors++;
      $display("FAIL redirect_target: valid=%0b pc=%0d instr=%h, required 1 8 %h", valid, pc, instr, mem[8]);
    end
  endtask

  task automatic test_halt();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (valid === 1'b1 && pc === 32'd5) begin
        checks++;
        errors++;
        $display("FAIL skipped_word: pc=5 presented after redirect, required never");
      end
      if (valid === 1'b1 && pc === 32'd15) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL halt_reach: pc=%0d valid=%0b, required pc 15 within 20 cycles", pc, valid);
    end
    checks++;
    if (done !== 1'b0 || imem_addr !== 32'd15 || instr !== mem[15]) begin
      errors++;
      $display("FAIL last_word: done=%0b addr=%0d instr=%h, required 0 15 %h", done, imem_addr, instr, mem[15]);
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'd15) begin
      errors++;
      $display("FAIL done_flag: done=%0b valid=%0b addr=%0d, required 1 0 15", done, valid, imem_addr);
    end
    redirect = 1'b1; redirect_addr = 32'd3;
    tick();
    redirect = 1'b0;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'd15) begin
      errors++;
      $display("FAIL halt_ignores_redirect: done=%0b valid=%0b addr=%0d, required 1 0 15", done, valid, imem_addr);
    end
  endtask

  task automatic test_fault();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    redirect = 1'b1; redirect_addr = 32'd20;
    tick();
    redirect = 1'b0;
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || done !== 1'b0 || imem_addr !== 32'd2) begin
      errors++;
      $display("FAIL fault_set: fault=%0b valid=%0b done=%0b addr=%0d, required 1 0 0 2",
               fault, valid, done, imem_addr);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: fault=%0b done=%0b valid=%0b, required 1 0 0", fault, done, valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (fault !== 1'b0 || valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL fault_clear: fault=%0b valid=%0b addr=%0d, required 0 0 0", fault, valid, imem_addr);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || pc !== 32'd0 || instr !== mem[0]) begin
      errors++;
      $display("FAIL restart_word: valid=%0b pc=%0d instr=%h, required 1 0 %h", valid, pc, instr, mem[0]);
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (valid !== 1'b0 || pc !== 32'd0 || imem_addr !== 32'd0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b pc=%0d addr=%0d instr=%h, required 0 0 0 0",
               valid, pc, imem_addr, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL no_fetch_after_reset: valid=%0b addr=%0d, required 0 0", valid, imem_addr);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      start         = ($urandom_range(0, 19) == 0);
      ready         = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = 32'($urandom_range(0, 19));
      tick();
      checks++;
      if (valid !== m_have || pc !== 32'(m_pc) || instr !== m_word || imem_addr !== 32'(m_next) ||
          fault !== m_fault || done !== (m_mode == 2 && !m_have && !m_fault)) begin
        errors++;
        $display("FAIL random[%0d]: valid=%0b pc=%0d instr=%h addr=%0d done=%0b fault=%0b, required %0b %0d %h %0d %0b %0b",
                 i, valid, pc, instr, imem_addr, done, fault,
                 m_have, m_pc, m_word, m_next, (m_mode == 2 && !m_have && !m_fault), m_fault);
      end
    end
    start = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h00011020;
    mem[1] = 32'h00011823;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_fault();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
